// File: rtl/priority_irq_pkg.sv
// Shared types and sizing helpers for the priority interrupt controller and its encoder.
package priority_irq_pkg;

    localparam int IRQ_N_DEFAULT = 24;

    function automatic int irq_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/priority_generic_encoder.sv
// Combinational priority encoder: highest set request index wins; any_o flags a valid index.
module priority_generic_encoder
    import priority_irq_pkg::*;
#(
    parameter  int N   = IRQ_N_DEFAULT,
    localparam int IDW = irq_id_width(N)
) (
    input  logic [N-1:0]   req_i,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
                idx_o = IDW'(k);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_irq_controller.sv
// Interrupt front-end: pending/mask, priority pick, registered index on a valid/ready handshake.
// Define PRIORITY_IRQ_LEVEL_MODE_EN for level-sensitive pending instead of edge latching.
module priority_irq_controller
    import priority_irq_pkg::*;
#(
    parameter  int N   = IRQ_N_DEFAULT,
    localparam int IDW = irq_id_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   irq_in,
    input  logic [N-1:0]   mask,
    output logic           irq_valid,
    input  logic           irq_ready,
    output logic [IDW-1:0] irq_id,
    output logic           irq_any,
    output logic [N-1:0]   pending
);

    irq_state_e     state_q, state_d;
    logic [N-1:0]   pending_q, pending_d, eligible;
    logic [IDW-1:0] irq_id_q, irq_id_d, enc_idx;
    logic           irq_any_q, enc_any, handshake;

    assign eligible  = pending_q & mask;
    assign handshake = (state_q == PRESENT) && irq_ready;

    priority_generic_encoder #(.N(N)) u_encoder (
        .req_i (eligible),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

`ifdef PRIORITY_IRQ_LEVEL_MODE_EN
    assign pending_d = irq_in;
`else
    logic [N-1:0] irq_prev_q, rise, clr;

    assign rise      = irq_in & ~irq_prev_q;
    assign clr       = handshake ? (N'(1) << irq_id_q) : '0;
    // Rise is OR-ed in after the clear so a same-cycle re-request survives the acknowledge.
    assign pending_d = (pending_q & ~clr) | rise;

    // History resets to ones: lines already high when reset releases must not pend.
    always_ff @(posedge clk) begin
        if (rst) irq_prev_q <= '1;
        else     irq_prev_q <= irq_in;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            irq_id_q  <= '0;
            irq_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_id_q  <= irq_id_d;
            irq_any_q <= |eligible;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_any)   state_d = PRESENT;
            PRESENT: if (handshake) state_d = IDLE;
        endcase
    end

    // Capture only when something is eligible; the encoder's idle index is never used.
    always_comb begin
        irq_id_d  = irq_id_q;
        irq_valid = (state_q == PRESENT);
        if ((state_q == IDLE) && enc_any) irq_id_d = enc_idx;
    end

    assign irq_id  = irq_id_q;
    assign irq_any = irq_any_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Scoreboard bench for priority_irq_controller: directed scenarios plus randomized traffic
// checked against a per-line behavioural model (honours PRIORITY_IRQ_LEVEL_MODE_EN).
module tb_priority_irq_controller;
    import priority_irq_pkg::*;

    localparam int N   = IRQ_N_DEFAULT;
    localparam int IDW = irq_id_width(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   irq_in = '0;
    logic [N-1:0]   mask = '1;
    logic           irq_ready = 1'b1;
    logic           irq_valid, irq_any;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   pending;

    priority_irq_controller #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_id    (irq_id),
        .irq_any   (irq_any),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-line pending flags, a busy flag for the presented grant.
    bit m_pend[N];
    bit m_prev[N];
    bit m_busy;
    int m_id;
    bit m_any;
    int exp_q[$];

    function automatic int highest(input bit [N-1:0] v);
        for (int k = N - 1; k >= 0; k--) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_step();
        bit [N-1:0] elig;
        int win;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 1'b0;
                m_prev[k] = 1'b1;
            end
            m_busy = 1'b0;
            m_id   = 0;
            m_any  = 1'b0;
            exp_q.delete();
            return;
        end
        elig = '0;
        for (int k = 0; k < N; k++) elig[k] = m_pend[k] && mask[k];
        m_any = (elig != '0);
        win   = highest(elig);
        if (m_busy && irq_ready) begin
            m_busy = 1'b0;
`ifndef PRIORITY_IRQ_LEVEL_MODE_EN
            m_pend[m_id] = 1'b0;
`endif
        end else if (!m_busy && win >= 0) begin
            m_busy = 1'b1;
            m_id   = win;
            exp_q.push_back(win);
        end
        for (int k = 0; k < N; k++) begin
`ifdef PRIORITY_IRQ_LEVEL_MODE_EN
            m_pend[k] = irq_in[k];
`else
            if (irq_in[k] && !m_prev[k]) m_pend[k] = 1'b1;
`endif
            m_prev[k] = irq_in[k];
        end
    endtask

    always @(posedge clk) model_step();

    // Monitor: compares status every cycle, pops the scoreboard on each new presentation.
    bit mon_en    = 1'b0;
    bit was_valid = 1'b0;
    int cur_exp   = 0;

    always @(negedge clk) begin
        bit [N-1:0] mp;
        if (mon_en) begin
            for (int k = 0; k < N; k++) mp[k] = m_pend[k];
            check("pending", 32'(pending), 32'(mp));
            check("irq_any", 32'(irq_any), 32'(m_any));
            check("irq_valid", 32'(irq_valid), 32'(m_busy));
            if (irq_valid === 1'b1) begin
                if (!was_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL grant: DUT presented id %0d, scoreboard empty at %0t", irq_id, $time);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("grant_id", 32'(irq_id), 32'(cur_exp));
                    end
                end else begin
                    check("id_hold", 32'(irq_id), 32'(cur_exp));
                end
            end
            was_valid = (irq_valid === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        irq_in    = 24'h000001;
        mask      = '1;
        irq_ready = 1'b1;
        rst       = 1'b1;
        tick(3);
        mon_en = 1'b1;
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        tick(4);
`ifndef PRIORITY_IRQ_LEVEL_MODE_EN
        check("held_line_no_pend", 32'(pending), 32'd0);
        check("held_line_no_valid", 32'(irq_valid), 32'd0);

        // Simultaneous rises on 3 and 17: 17 first, then 3 after the bubble.
        irq_in = 24'h000001 | (24'd1 << 3) | (24'd1 << 17);
        tick(1);
        check("two_rise_pend", 32'(pending), 32'((24'd1 << 3) | (24'd1 << 17)));
        check("two_rise_lat", 32'(irq_valid), 32'd0);
        tick(1);
        check("first_valid", 32'(irq_valid), 32'd1);
        check("first_id", 32'(irq_id), 32'd17);
        tick(1);
        check("bubble", 32'(irq_valid), 32'd0);
        check("clr17", 32'(pending), 32'(24'd1 << 3));
        tick(1);
        check("second_id", 32'(irq_id), 32'd3);
        tick(1);
        check("drained", 32'(pending), 32'd0);

        // Masked pending persists, then becomes eligible.
        irq_in = 24'd1 << 5;
        mask   = ~(24'd1 << 5);
        tick(3);
        check("masked_pend", 32'(pending), 32'(24'd1 << 5));
        check("masked_any", 32'(irq_any), 32'd0);
        check("masked_valid", 32'(irq_valid), 32'd0);
        mask = '1;
        tick(1);
        check("unmask_valid", 32'(irq_valid), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd5);
        check("unmask_any", 32'(irq_any), 32'd1);
        tick(1);

        // No retraction while stalled.
        irq_in = '0;
        tick(1);
        irq_in    = 24'd1 << 4;
        irq_ready = 1'b0;
        tick(2);
        check("stall_id", 32'(irq_id), 32'd4);
        irq_in = (24'd1 << 4) | (24'd1 << 20);
        tick(3);
        check("no_retract_valid", 32'(irq_valid), 32'd1);
        check("no_retract_id", 32'(irq_id), 32'd4);
        irq_ready = 1'b1;
        tick(2);
        check("next_id", 32'(irq_id), 32'd20);
        tick(1);
        check("drained2", 32'(pending), 32'd0);

        // Re-rise on the line being acknowledged keeps it pending.
        irq_in = '0;
        tick(1);
        irq_in    = 24'd1 << 9;
        irq_ready = 1'b0;
        tick(2);
        irq_in = '0;
        tick(1);
        check("hold9", 32'(irq_id), 32'd9);
        irq_in    = 24'd1 << 9;
        irq_ready = 1'b1;
        tick(1);
        check("rise_wins", 32'(pending), 32'(24'd1 << 9));
        tick(1);
        check("re_present", 32'(irq_id), 32'd9);
        tick(1);
        check("drained3", 32'(pending), 32'd0);
`else
        irq_in = '0;
        tick(4);
        irq_in = 24'd1 << 12;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("level_valid", 32'(irq_valid), 32'((k >= 2) && (k % 2 == 0)));
            if (k >= 2 && k % 2 == 0) check("level_id", 32'(irq_id), 32'd12);
        end
`endif

        // Reset while presenting drops the grant and pending state.
        irq_in = '0;
        tick(2);
        irq_in    = 24'd1 << 7;
        irq_ready = 1'b0;
        tick(2);
        check("pre_rst_id", 32'(irq_id), 32'd7);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", 32'(irq_valid), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        rst       = 1'b0;
        irq_ready = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            irq_in    = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(0, 7) == 0) mask = N'($urandom);
            irq_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/priority_irq_controller.md
Name: priority_irq_controller

Overview:
- Sequential interrupt front-end that latches request edges into a pending register and applies a mask.
- Feeds the masked pending vector to the team's combinational priority_generic_encoder.
- Registers the winning index and presents it downstream on a valid/ready handshake.
- Sits between raw peripheral request lines and the interrupt-servicing FSM.

Parameters:
- N, 24, number of request lines.
- IDW, $clog2(N), width of the encoded index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  N  raw request lines.
- mask  input  N  1 = line enabled; 0 = pending kept but not eligible.
- irq_valid  output  1  registered index available.
- irq_ready  input  1  consumer accepts index.
- irq_id  output  IDW  winning line index, stable while irq_valid=1.
- irq_any  output  1  OR of (pending & mask), registered.
- pending  output  N  pending register, for status readback.

Behaviour:
- Reset, synchronous and active-high on clk:
  - pending=0, irq_valid=0, irq_id=0, irq_any=0, state=IDLE.
  - Edge-history register irq_prev is set to all ones, so lines already high when reset releases do not pend.
- Edge detect: rise[k] = irq_in[k] & ~irq_prev[k]. irq_prev <= irq_in every cycle.
- Pending update:
  - pending <= (pending & ~clr) | rise.
  - clr is one-hot at irq_id on a handshake, else 0.
  - If a rise and a clear hit the same bit in the same cycle, the rise wins and the bit stays set.
- Priority: eligible = pending & mask. The highest set index wins (index N-1 is highest), computed by the encoder.
- FSM:
  - IDLE: if any eligible bit is set, irq_id <= encoder index, irq_valid <= 1, go to PRESENT. Request-to-valid latency is 2 cycles after the irq_in rise (pend cycle, then capture cycle).
  - PRESENT: hold irq_id and irq_valid. On irq_valid & irq_ready, clear pending[irq_id], irq_valid <= 0, go to IDLE.
- Throughput: at most one grant every 2 cycles, because of the mandatory IDLE bubble.
- No retraction: a mask change or a new higher-priority rise during PRESENT does not alter irq_id or drop irq_valid.
- Masked-pending bits persist indefinitely and become eligible once unmasked.
- irq_any is registered from eligible with 1-cycle lag. It is independent of FSM state.
- The encoder's don't-care index output is never captured; capture happens only when eligible is non-zero.
- Reset asserted mid-PRESENT drops irq_valid on the next edge. Any in-flight grant is lost and pending is cleared.

Optional Feature:
- Macro: PRIORITY_IRQ_LEVEL_MODE_EN.
- Defined: level-sensitive mode.
  - pending <= irq_in each cycle; the register ignores clr and the edge logic is removed.
  - The handshake only returns the FSM to IDLE.
  - A line still high re-presents after the bubble.
- Undefined: edge-latched behaviour as above.

Decomposition:
- Package priority_irq_pkg holds:
  - default N constant;
  - id-width function (ceil log2);
  - state enum {IDLE, PRESENT}.
- One sub-module: priority_generic_encoder instantiated with N=N.
  - Its "any" output gates the IDLE capture.
  - Its index output provides irq_id.

Test Plan:
- Reset release with irq_in=24'h000001 held high -> no pending, irq_valid stays 0.
- Rise on bits 3 and 17 in the same cycle, mask all ones, irq_ready=1 -> irq_id=17 valid 2 cycles later, then irq_id=3 after the bubble, pending returns to 0.
- Rise on bit 5 with mask[5]=0 -> pending[5]=1, irq_any=0, no valid. Set mask[5]=1 -> irq_id=5 presented.
- irq_ready=0 while irq_id=4 presented, rise on bit 20 -> irq_id stays 4. After ready, 20 is presented next.
- Handshake on id=9 in the same cycle as a new rise on bit 9 -> pending[9] stays 1 and is re-presented.
- With PRIORITY_IRQ_LEVEL_MODE_EN, hold bit 12 high for 10 cycles with irq_ready=1 -> irq_id=12 valid every other cycle.
